// File: rtl/rps_match_scorer_if.sv
// rtl/rps_match_scorer_if.sv - round input and score output bundle for rps_match_scorer
//
// Purpose: groups the round/match-control inputs and the registered score
// outputs of rps_match_scorer so they travel as one port.
// Optional: RPS_STREAK_EN adds streak_player, streak_len and best_streak.
//
// Signals:
//   new_match      master->slave  start/restart a match (one-cycle pulse)
//   round_valid    master->slave  winner is valid this cycle (one-cycle pulse)
//   winner[1:0]    master->slave  00 tie, 01 P1, 10 P2, 11 invalid
//   p1_score, p2_score, tie_count, invalid_count   slave->master  counts
//   score_upd      slave->master  an accepted round was applied
//   match_active   slave->master  match in progress
//   match_done     slave->master  match decided
//   match_winner   slave->master  00 none, 01 P1, 10 P2

interface rps_match_scorer_if #(
    parameter int SCORE_W = 4
);
    logic               new_match;
    logic               round_valid;
    logic [1:0]         winner;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [SCORE_W-1:0] tie_count;
    logic [SCORE_W-1:0] invalid_count;
    logic               score_upd;
    logic               match_active;
    logic               match_done;
    logic [1:0]         match_winner;
`ifdef RPS_STREAK_EN
    logic [1:0]         streak_player;
    logic [SCORE_W-1:0] streak_len;
    logic [SCORE_W-1:0] best_streak;
`endif

    modport master (
`ifdef RPS_STREAK_EN
        input  streak_player, streak_len, best_streak,
`endif
        output new_match, round_valid, winner,
        input  p1_score, p2_score, tie_count, invalid_count,
        input  score_upd, match_active, match_done, match_winner
    );

    modport slave (
`ifdef RPS_STREAK_EN
        output streak_player, streak_len, best_streak,
`endif
        input  new_match, round_valid, winner,
        output p1_score, p2_score, tie_count, invalid_count,
        output score_upd, match_active, match_done, match_winner
    );
endinterface

// File: rtl/rps_match_scorer.sv
// rtl/rps_match_scorer.sv - first-to-N match scorer for the stone-paper-scissors judge
//
// Purpose: consumes one winner code per round, keeps P1/P2 scores plus
// saturating tie/invalid counts, and declares the match winner when a player
// reaches WINS_TO_MATCH. All outputs are registered (latency 1).
// Optional: define RPS_STREAK_EN for streak_player/streak_len/best_streak.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   rps_match_scorer_if.slave (round inputs, score outputs)

module rps_match_scorer #(
    parameter int WINS_TO_MATCH = 3,
    parameter int SCORE_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rps_match_scorer_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WINS_TO_MATCH);
    localparam logic [SCORE_W-1:0] SAT_MAX   = '1;
    localparam logic [SCORE_W-1:0] ONE       = SCORE_W'(1);

    state_t             state, state_n;
    logic [SCORE_W-1:0] p1_q, p1_n, p2_q, p2_n;
    logic [SCORE_W-1:0] tie_q, tie_n, inv_q, inv_n;
    logic               upd_q, upd_n;
    logic [1:0]         mw_q, mw_n;
    logic               active_q, done_q;
    logic               clear;
`ifdef RPS_STREAK_EN
    logic [1:0]         sp_q, sp_n;
    logic [SCORE_W-1:0] sl_q, sl_n, best_q, best_n;
`endif

    always_comb begin
        state_n = state;
        p1_n    = p1_q;
        p2_n    = p2_q;
        tie_n   = tie_q;
        inv_n   = inv_q;
        mw_n    = mw_q;
        upd_n   = 1'b0;
        clear   = 1'b0;
`ifdef RPS_STREAK_EN
        sp_n    = sp_q;
        sl_n    = sl_q;
        best_n  = best_q;
`endif
        case (state)
            IDLE: begin
                if (bus.new_match) begin
                    state_n = PLAY;
                    clear   = 1'b1;
                end
            end
            PLAY: begin
                // new_match outranks a coincident round: the round is dropped
                if (bus.new_match) begin
                    clear = 1'b1;
                end else if (bus.round_valid) begin
                    upd_n = 1'b1;
                    case (bus.winner)
                        2'b01: begin
                            p1_n = p1_q + ONE;
                            if (p1_n == WIN_SCORE) begin
                                state_n = OVER;
                                mw_n    = 2'b01;
                            end
                        end
                        2'b10: begin
                            p2_n = p2_q + ONE;
                            if (p2_n == WIN_SCORE) begin
                                state_n = OVER;
                                mw_n    = 2'b10;
                            end
                        end
                        2'b00: if (tie_q != SAT_MAX) tie_n = tie_q + ONE;
                        default: if (inv_q != SAT_MAX) inv_n = inv_q + ONE;
                    endcase
                end
            end
            OVER: begin
                if (bus.new_match) begin
                    state_n = PLAY;
                    clear   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

`ifdef RPS_STREAK_EN
        // Invalid rounds are transparent to the streak; ties break it.
        if (upd_n) begin
            case (bus.winner)
                2'b00: begin
                    sp_n = 2'b00;
                    sl_n = '0;
                end
                2'b01, 2'b10: begin
                    if (sp_q == bus.winner) begin
                        if (sl_q != SAT_MAX) sl_n = sl_q + ONE;
                    end else begin
                        sp_n = bus.winner;
                        sl_n = ONE;
                    end
                end
                default: ;
            endcase
            if (sl_n > best_q) best_n = sl_n;
        end
`endif

        if (clear) begin
            p1_n  = '0;
            p2_n  = '0;
            tie_n = '0;
            inv_n = '0;
            mw_n  = 2'b00;
`ifdef RPS_STREAK_EN
            sp_n   = 2'b00;
            sl_n   = '0;
            best_n = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            p1_q     <= '0;
            p2_q     <= '0;
            tie_q    <= '0;
            inv_q    <= '0;
            upd_q    <= 1'b0;
            mw_q     <= 2'b00;
            active_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef RPS_STREAK_EN
            sp_q     <= 2'b00;
            sl_q     <= '0;
            best_q   <= '0;
`endif
        end else begin
            state    <= state_n;
            p1_q     <= p1_n;
            p2_q     <= p2_n;
            tie_q    <= tie_n;
            inv_q    <= inv_n;
            upd_q    <= upd_n;
            mw_q     <= mw_n;
            active_q <= (state_n == PLAY);
            done_q   <= (state_n == OVER);
`ifdef RPS_STREAK_EN
            sp_q     <= sp_n;
            sl_q     <= sl_n;
            best_q   <= best_n;
`endif
        end
    end

    assign bus.p1_score      = p1_q;
    assign bus.p2_score      = p2_q;
    assign bus.tie_count     = tie_q;
    assign bus.invalid_count = inv_q;
    assign bus.score_upd     = upd_q;
    assign bus.match_active  = active_q;
    assign bus.match_done    = done_q;
    assign bus.match_winner  = mw_q;
`ifdef RPS_STREAK_EN
    assign bus.streak_player = sp_q;
    assign bus.streak_len    = sl_q;
    assign bus.best_streak   = best_q;
`endif
endmodule

// File: tb/tb_rps_match_scorer.sv
// tb/tb_rps_match_scorer.sv - scoreboard testbench for rps_match_scorer

module tb_rps_match_scorer;
    localparam int SW   = 2;
    localparam int WINS = 3;
    localparam int MAXV = (1 << SW) - 1;

    typedef struct {
        int upd;
        int active;
        int done;
        int mw;
        int p1;
        int p2;
        int tie;
        int inv;
        int sp;
        int sl;
        int best;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rps_match_scorer_if #(.SCORE_W(SW)) bus_if ();

    rps_match_scorer #(.WINS_TO_MATCH(WINS), .SCORE_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // reference model: match bookkeeping from the rules, streak from round history
    int m_p1, m_p2, m_tie, m_inv, m_mw, m_best;
    int m_active, m_done;
    int hist[$];

    task automatic chk(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // current streak = trailing run of one player's wins, invalid rounds skipped
    task automatic streak_of(output int sp, output int sl);
        sp = 0;
        sl = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == 3) continue;
            if (sp == 0) begin
                if (hist[i] == 0) break;
                sp = hist[i];
                sl = 1;
            end else if (hist[i] == sp) begin
                sl++;
            end else begin
                break;
            end
        end
        if (sl > MAXV) sl = MAXV;
    endtask

    task automatic model_clear();
        m_p1 = 0; m_p2 = 0; m_tie = 0; m_inv = 0; m_mw = 0; m_best = 0;
        hist.delete();
    endtask

    task automatic model_step(input bit r, input bit nm, input bit rv, input int w);
        exp_t e;
        int sp, sl;
        e.upd = 0;
        if (r) begin
            model_clear();
            m_active = 0;
            m_done = 0;
        end else if (nm) begin
            model_clear();
            m_active = 1;
            m_done = 0;
        end else if (rv && m_active == 1) begin
            e.upd = 1;
            case (w)
                1: begin
                    m_p1++;
                    if (m_p1 == WINS) begin m_active = 0; m_done = 1; m_mw = 1; end
                end
                2: begin
                    m_p2++;
                    if (m_p2 == WINS) begin m_active = 0; m_done = 1; m_mw = 2; end
                end
                0: m_tie = (m_tie < MAXV) ? m_tie + 1 : MAXV;
                default: m_inv = (m_inv < MAXV) ? m_inv + 1 : MAXV;
            endcase
            hist.push_back(w);
        end
        streak_of(sp, sl);
        if (sl > m_best) m_best = sl;
        e.active = m_active;
        e.done = m_done;
        e.mw = m_mw;
        e.p1 = m_p1;
        e.p2 = m_p2;
        e.tie = m_tie;
        e.inv = m_inv;
        e.sp = sp;
        e.sl = sl;
        e.best = m_best;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit nm, input bit rv, input int w);
        @(negedge clk);
        rst = r;
        bus_if.new_match = nm;
        bus_if.round_valid = rv;
        bus_if.winner = w[1:0];
        model_step(r, nm, rv, w);
    endtask

    task automatic rounds(input int w0, input int w1, input int w2, input int w3, input int n);
        int ws[4];
        ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
        for (int i = 0; i < n; i++) cyc(0, 0, 1, ws[i]);
    endtask

    // monitor: one expected record per clock, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("score_upd", int'(bus_if.score_upd), e.upd);
                chk("match_active", int'(bus_if.match_active), e.active);
                chk("match_done", int'(bus_if.match_done), e.done);
                chk("match_winner", int'(bus_if.match_winner), e.mw);
                chk("p1_score", int'(bus_if.p1_score), e.p1);
                chk("p2_score", int'(bus_if.p2_score), e.p2);
                chk("tie_count", int'(bus_if.tie_count), e.tie);
                chk("invalid_count", int'(bus_if.invalid_count), e.inv);
`ifdef RPS_STREAK_EN
                chk("streak_player", int'(bus_if.streak_player), e.sp);
                chk("streak_len", int'(bus_if.streak_len), e.sl);
                chk("best_streak", int'(bus_if.best_streak), e.best);
`endif
            end
        end
    end

    initial begin
        bit r, nm;
        int x;
        rst = 1'b1;
        bus_if.new_match = 1'b0;
        bus_if.round_valid = 1'b0;
        bus_if.winner = 2'b00;
        m_active = 0;
        m_done = 0;
        model_clear();

        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 1);
        cyc(0, 0, 1, 1);            // IDLE ignores rounds
        cyc(0, 1, 0, 0);
        rounds(1, 1, 1, 0, 3);      // P1 takes the match
        cyc(0, 0, 1, 2);            // ignored in OVER
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        rounds(2, 0, 3, 2, 4);
        cyc(0, 1, 0, 0);
        rounds(1, 1, 0, 0, 2);
        cyc(0, 1, 1, 1);            // restart beats coincident round
        cyc(0, 0, 0, 0);
        rounds(0, 0, 0, 0, 4);
        rounds(0, 3, 3, 3, 4);      // tie and invalid saturate
        cyc(1, 0, 1, 1);            // reset mid-match
        cyc(0, 0, 1, 1);
        cyc(0, 1, 0, 0);
        rounds(1, 1, 2, 0, 4);      // streak sequence
        rounds(3, 1, 0, 0, 2);
        cyc(0, 1, 0, 0);
        rounds(2, 2, 3, 2, 4);

        for (int i = 0; i < 3000; i++) begin
            x  = $urandom_range(0, 99);
            r  = (x < 2);
            nm = (x >= 2 && x < 9);
            cyc(r, nm, $urandom_range(0, 1) == 1, $urandom_range(0, 3));
        end
        cyc(0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
